// File: rtl/int_to_float_pipe_if.sv
// Valid/ready stream bundle for the integer-to-float32 converter.
// The master drives operands and sinks results; the slave is the converter.
interface int_to_float_pipe_if #(
   parameter int INT_WIDTH = 32
);
   logic                 in_valid;
   logic                 in_ready;
   logic [INT_WIDTH-1:0] in_data;
   logic                 in_signed;
   logic                 out_valid;
   logic                 out_ready;
   logic [31:0]          out_float;
   logic                 out_inexact;

   modport master (
      output in_valid, in_data, in_signed, out_ready,
      input  in_ready, out_valid, out_float, out_inexact
   );

   modport slave (
      input  in_valid, in_data, in_signed, out_ready,
      output in_ready, out_valid, out_float, out_inexact
   );
endinterface

// File: rtl/int_to_float_pipe.sv
// Signed/unsigned integer to IEEE-754 float32 converter, round-to-nearest-even.
// Latency 3 cycles, 1/cycle; all stages stall together while the output is held.
module int_to_float_pipe #(
   parameter int INT_WIDTH = 32
) (
   input logic                clk,
   input logic                reset_n,
   int_to_float_pipe_if.slave bus
);
   localparam int PAD = 32 - INT_WIDTH;

   logic                 adv;

   logic                 s1_vld_q;
   logic                 s1_sign_q, s1_sign_d;
   logic [INT_WIDTH-1:0] s1_mag_q, s1_mag_d;

   logic                 s2_vld_q;
   logic                 s2_sign_q;
   logic                 s2_zero_q, s2_zero_d;
   logic [4:0]           s2_p_q, s2_p_d;
   logic [INT_WIDTH-2:0] s2_frac_q, s2_frac_d;
   logic [INT_WIDTH-1:0] shifted;

   logic                 out_vld_q;
   logic [31:0]          out_float_q, out_float_d;
   logic                 out_inexact_q, out_inexact_d;

   logic [30:0]          f31;
   logic [22:0]          frac;
   logic                 guard, sticky, rup;
   logic [23:0]          rsum;
   logic [7:0]           expo;

   assign adv             = !out_vld_q | bus.out_ready;
   assign bus.in_ready    = adv;
   assign bus.out_valid   = out_vld_q;
   assign bus.out_float   = out_float_q;
   assign bus.out_inexact = out_inexact_q;

   // S1: the most negative operand negates to 2^(W-1), still correct as unsigned
   always_comb begin
      s1_sign_d = bus.in_signed & bus.in_data[INT_WIDTH-1];
      s1_mag_d  = bus.in_data;
      if (s1_sign_d)
         s1_mag_d = ~bus.in_data + {{(INT_WIDTH-1){1'b0}}, 1'b1};
   end

   // S2: leading-one position; after the shift the MSB doubles as the non-zero flag
   always_comb begin
      s2_p_d = '0;
      for (int i = 0; i < INT_WIDTH; i++) begin
         if (s1_mag_q[i])
            s2_p_d = 5'(i);
      end
      shifted   = s1_mag_q << (5'(INT_WIDTH - 1) - s2_p_d);
      s2_zero_d = !shifted[INT_WIDTH-1];
      s2_frac_d = shifted[INT_WIDTH-2:0];
   end

   // S3: bits below the hidden one are left-aligned, so guard/sticky are zero when p <= 23
   always_comb begin
      f31    = 31'(s2_frac_q) << PAD;
      frac   = f31[30:8];
      guard  = f31[7];
      sticky = |f31[6:0];
      rup    = guard & (sticky | frac[0]);
      rsum   = {1'b0, frac} + {23'd0, rup};
      expo   = {3'b000, s2_p_q} + 8'd127 + {7'd0, rsum[23]};
      out_float_d   = {s2_sign_q, expo, rsum[22:0]};
      out_inexact_d = guard | sticky;
      if (s2_zero_q) begin
         out_float_d   = '0;
         out_inexact_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_vld_q      <= 1'b0;
         s1_sign_q     <= 1'b0;
         s1_mag_q      <= '0;
         s2_vld_q      <= 1'b0;
         s2_sign_q     <= 1'b0;
         s2_zero_q     <= 1'b1;
         s2_p_q        <= '0;
         s2_frac_q     <= '0;
         out_vld_q     <= 1'b0;
         out_float_q   <= '0;
         out_inexact_q <= 1'b0;
      end else if (adv) begin
         s1_vld_q      <= bus.in_valid;
         s1_sign_q     <= s1_sign_d;
         s1_mag_q      <= s1_mag_d;
         s2_vld_q      <= s1_vld_q;
         s2_sign_q     <= s1_sign_q;
         s2_zero_q     <= s2_zero_d;
         s2_p_q        <= s2_p_d;
         s2_frac_q     <= s2_frac_d;
         out_vld_q     <= s2_vld_q;
         out_float_q   <= out_float_d;
         out_inexact_q <= out_inexact_d;
      end
   end
endmodule

// File: tb/tb_int_to_float_pipe.sv
// Directed bench for int_to_float_pipe: 32-bit and 8-bit instances, hand-computed floats.
module tb_int_to_float_pipe;
   logic clk = 1'b0;
   logic reset_n;
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   int_to_float_pipe_if #(.INT_WIDTH(32)) bus ();
   int_to_float_pipe_if #(.INT_WIDTH(8))  bus8 ();

   int_to_float_pipe #(.INT_WIDTH(32)) dut  (.clk(clk), .reset_n(reset_n), .bus(bus));
   int_to_float_pipe #(.INT_WIDTH(8))  dut8 (.clk(clk), .reset_n(reset_n), .bus(bus8));

   logic [31:0] st_data [$];
   bit          st_sgn  [$];
   logic [31:0] cap_f   [$];
   logic        cap_x   [$];
   int          bp_ready_low;
   int          bp_hold_bad;

   // Streams st_data through the 32-bit DUT, stalling out_ready in a cycle window, capturing results.
   task automatic run_stream(input int stall_from, input int stall_len);
      int          idx = 0;
      int          c = 0;
      logic        prev_stall = 1'b0;
      logic [31:0] prev_f = '0;
      logic        prev_x = 1'b0;
      cap_f.delete();
      cap_x.delete();
      bp_ready_low = 0;
      bp_hold_bad  = 0;
      while (cap_f.size() < st_data.size() && c < 200) begin
         @(negedge clk);
         bus.out_ready = !(c >= stall_from && c < stall_from + stall_len);
         #1;
         if (prev_stall && (!bus.out_valid || bus.out_float !== prev_f || bus.out_inexact !== prev_x))
            bp_hold_bad++;
         prev_stall = bus.out_valid && !bus.out_ready;
         prev_f     = bus.out_float;
         prev_x     = bus.out_inexact;
         if (!bus.out_ready && !bus.in_ready)
            bp_ready_low++;
         if (bus.out_valid && bus.out_ready) begin
            cap_f.push_back(bus.out_float);
            cap_x.push_back(bus.out_inexact);
         end
         if (idx < st_data.size()) begin
            bus.in_valid  = 1'b1;
            bus.in_data   = st_data[idx];
            bus.in_signed = st_sgn[idx];
            if (bus.in_ready)
               idx++;
         end else begin
            bus.in_valid = 1'b0;
         end
         c++;
      end
      @(negedge clk);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
   endtask

   task automatic test_reset;
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      n_cmp++;
      if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid got=%b want=0", bus.out_valid); end
      n_cmp++;
      if (bus.out_float !== 32'h0) begin n_bad++; $display("FAIL rst_out_float got=%h want=00000000", bus.out_float); end
      n_cmp++;
      if (bus.out_inexact !== 1'b0) begin n_bad++; $display("FAIL rst_out_inexact got=%b want=0", bus.out_inexact); end
      n_cmp++;
      if (bus8.out_valid !== 1'b0) begin n_bad++; $display("FAIL rst8_out_valid got=%b want=0", bus8.out_valid); end
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      n_cmp++;
      if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready got=%b want=1", bus.in_ready); end
   endtask

   task automatic test_latency;
      logic [31:0] vin  [3] = '{32'd7, 32'hFFFF_FFFF, 32'd0};
      logic [31:0] vexp [3] = '{32'h40E0_0000, 32'hBF80_0000, 32'h0000_0000};
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         bus.out_ready = 1'b1;
         #1;
         if (c >= 1 && c < 3) begin
            n_cmp++;
            if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL lat_early[%0d] out_valid got=%b want=0", c, bus.out_valid); end
         end else if (c >= 3) begin
            n_cmp++;
            if (bus.out_valid !== 1'b1 || bus.out_float !== vexp[c-3] || bus.out_inexact !== 1'b0) begin
               n_bad++;
               $display("FAIL lat[%0d] got valid=%b float=%h inexact=%b want valid=1 float=%h inexact=0",
                        c - 3, bus.out_valid, bus.out_float, bus.out_inexact, vexp[c-3]);
            end
         end
         bus.in_valid  = (c < 3);
         bus.in_signed = 1'b1;
         bus.in_data   = (c < 3) ? vin[c] : 32'd0;
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic test_extremes;
      logic [31:0] ef [3] = '{32'hCF00_0000, 32'h4F80_0000, 32'h4F00_0000};
      logic        ex [3] = '{1'b0, 1'b1, 1'b1};
      st_data = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF};
      st_sgn  = '{1'b1, 1'b0, 1'b1};
      run_stream(1000, 0);
      n_cmp++;
      if (cap_f.size() !== 3) begin n_bad++; $display("FAIL ext_count got=%0d want=3", cap_f.size()); end
      for (int i = 0; i < cap_f.size() && i < 3; i++) begin
         n_cmp++;
         if (cap_f[i] !== ef[i] || cap_x[i] !== ex[i]) begin
            n_bad++;
            $display("FAIL ext[%0d] got float=%h inexact=%b want float=%h inexact=%b", i, cap_f[i], cap_x[i], ef[i], ex[i]);
         end
      end
   endtask

   task automatic test_round_even;
      logic [31:0] ef [4] = '{32'h4B80_0000, 32'h4B80_0002, 32'h4B80_0000, 32'hCB80_0002};
      logic        ex [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
      st_data = '{32'd16777217, 32'd16777219, 32'd16777216, 32'hFEFF_FFFD};
      st_sgn  = '{1'b0, 1'b0, 1'b0, 1'b1};
      run_stream(1000, 0);
      n_cmp++;
      if (cap_f.size() !== 4) begin n_bad++; $display("FAIL rne_count got=%0d want=4", cap_f.size()); end
      for (int i = 0; i < cap_f.size() && i < 4; i++) begin
         n_cmp++;
         if (cap_f[i] !== ef[i] || cap_x[i] !== ex[i]) begin
            n_bad++;
            $display("FAIL rne[%0d] got float=%h inexact=%b want float=%h inexact=%b", i, cap_f[i], cap_x[i], ef[i], ex[i]);
         end
      end
   endtask

   task automatic test_backpressure;
      logic [31:0] ef [5] = '{32'h3F80_0000, 32'hC000_0000, 32'h4040_0000, 32'hC47A_0000, 32'h4F80_0000};
      logic        ex [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      st_data = '{32'd1, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FC18, 32'hFFFF_FFFF};
      st_sgn  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      run_stream(4, 4);
      n_cmp++;
      if (bp_ready_low !== 4) begin n_bad++; $display("FAIL bp_in_ready_low_cycles got=%0d want=4", bp_ready_low); end
      n_cmp++;
      if (bp_hold_bad !== 0) begin n_bad++; $display("FAIL bp_hold_changes got=%0d want=0", bp_hold_bad); end
      n_cmp++;
      if (cap_f.size() !== 5) begin n_bad++; $display("FAIL bp_count got=%0d want=5", cap_f.size()); end
      for (int i = 0; i < cap_f.size() && i < 5; i++) begin
         n_cmp++;
         if (cap_f[i] !== ef[i] || cap_x[i] !== ex[i]) begin
            n_bad++;
            $display("FAIL bp[%0d] got float=%h inexact=%b want float=%h inexact=%b", i, cap_f[i], cap_x[i], ef[i], ex[i]);
         end
      end
   endtask

   task automatic test_mid_reset;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         bus.in_valid  = 1'b1;
         bus.in_signed = 1'b0;
         bus.in_data   = 32'd5 + 32'(i);
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      reset_n      = 1'b0;
      #1;
      n_cmp++;
      if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL mrst_out_valid got=%b want=0", bus.out_valid); end
      @(negedge clk);
      reset_n = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         #1;
         n_cmp++;
         if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL mrst_stale[%0d] out_valid got=%b want=0", c, bus.out_valid); end
      end
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         #1;
         if (c == 0) begin
            n_cmp++;
            if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL mrst_in_ready got=%b want=1", bus.in_ready); end
         end else if (c < 3) begin
            n_cmp++;
            if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL mrst_early[%0d] out_valid got=%b want=0", c, bus.out_valid); end
         end else begin
            n_cmp++;
            if (bus.out_valid !== 1'b1 || bus.out_float !== 32'h3F80_0000 || bus.out_inexact !== 1'b0) begin
               n_bad++;
               $display("FAIL mrst_result got valid=%b float=%h inexact=%b want valid=1 float=3f800000 inexact=0",
                        bus.out_valid, bus.out_float, bus.out_inexact);
            end
         end
         bus.in_valid  = (c == 0);
         bus.in_signed = 1'b0;
         bus.in_data   = 32'd1;
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic test_narrow;
      logic [7:0]  vin  [3] = '{8'h80, 8'h80, 8'hFF};
      logic        vsg  [3] = '{1'b1, 1'b0, 1'b1};
      logic [31:0] vexp [3] = '{32'hC300_0000, 32'h4300_0000, 32'hBF80_0000};
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         bus8.out_ready = 1'b1;
         #1;
         if (c >= 3) begin
            n_cmp++;
            if (bus8.out_valid !== 1'b1 || bus8.out_float !== vexp[c-3] || bus8.out_inexact !== 1'b0) begin
               n_bad++;
               $display("FAIL narrow[%0d] got valid=%b float=%h inexact=%b want valid=1 float=%h inexact=0",
                        c - 3, bus8.out_valid, bus8.out_float, bus8.out_inexact, vexp[c-3]);
            end
         end
         bus8.in_valid  = (c < 3);
         bus8.in_data   = (c < 3) ? vin[c] : 8'd0;
         bus8.in_signed = (c < 3) ? vsg[c] : 1'b0;
      end
      bus8.in_valid = 1'b0;
   endtask

   initial begin
      reset_n        = 1'b0;
      bus.in_valid   = 1'b0;
      bus.in_data    = '0;
      bus.in_signed  = 1'b0;
      bus.out_ready  = 1'b1;
      bus8.in_valid  = 1'b0;
      bus8.in_data   = '0;
      bus8.in_signed = 1'b0;
      bus8.out_ready = 1'b1;
      test_reset();
      test_latency();
      test_extremes();
      test_round_even();
      test_backpressure();
      test_mid_reset();
      test_narrow();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1);
   end
endmodule

// File: doc/int_to_float_pipe.md
Name: int_to_float_pipe

Overview:
- Pipelined, parametrised integer-to-IEEE-754 single-precision converter for the FPU datapath.
- Converts INT_WIDTH-bit operands to float32, interpreting each as signed or unsigned per transaction.
- Applies round-to-nearest-even when the magnitude exceeds 24 significant bits and flags inexact results.
- Uses a valid/ready stream interface on both sides, with full backpressure support.

Parameters:
- INT_WIDTH, 32, integer operand width; legal range 2..32.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand present on in_data.
- in_ready  output  1  converter can accept an operand this cycle.
- in_data  input  INT_WIDTH  integer operand.
- in_signed  input  1  1 = in_data is two's complement; 0 = unsigned.
- out_valid  output  1  result present on out_float.
- out_ready  input  1  downstream accepts the result.
- out_float  output  32  float32 result: {sign, exponent[7:0], fraction[22:0]}.
- out_inexact  output  1  result was rounded (nonzero bits discarded).

Behaviour:
- Reset: reset_n low asynchronously clears all stage valid bits and sets out_valid=0, out_float=0, out_inexact=0. in_ready=1 in the first cycle after release. In-flight operands are discarded without output.
- Pipeline: three register stages, S1→S2→S3. S3 registers drive the outputs.
- Advance: adv = !out_valid | out_ready. All stages shift together when adv=1 and hold when adv=0.
- Input handshake: in_ready = adv, combinational. An operand is accepted when in_valid & in_ready. A bubble (valid=0) enters S1 when in_valid=0.
- Latency: exactly 3 cycles from acceptance to out_valid with out_ready held high. Throughput is 1 result per cycle.
- S1, sign and magnitude:
  - sign = in_signed & in_data[INT_WIDTH-1].
  - mag = sign ? (~in_data + 1) : in_data, INT_WIDTH bits unsigned.
  - The most negative value (e.g. 0x80000000) yields mag = 2^(INT_WIDTH-1), which is correct as unsigned.
- S2, normalise:
  - Leading-one detector gives p = index of the highest set bit of mag; zero flag z = (mag==0).
  - Left-shift mag so the leading one sits at MSB, then register the normalised value, p, z and sign.
- S3, round and pack:
  - If p ≤ 23: fraction = bits below the leading one, zero-padded; exact; out_inexact=0.
  - If p > 23: keep 23 fraction bits. Guard = next bit; sticky = OR of all remaining bits.
  - Round up when guard & (sticky | fraction LSB).
  - out_inexact = guard | sticky.
  - If the round-up carries out of the fraction: fraction=0 and exponent+1.
- Exponent = p + 127. The maximum possible result is 2^32 (exponent 159), so there is no overflow or infinity.
- Zero: z=1 gives out_float=0x00000000 (+0, even for signed mode) and out_inexact=0.
- Output hold: while out_valid & !out_ready, out_float and out_inexact stay stable and no stage changes.
- Simultaneous accept and output: when out_valid & out_ready & in_valid, the output is consumed and the new operand enters S1 in the same cycle, with no bubble.

Test Plan:
- Reset/latency: INT_WIDTH=32, out_ready=1. Drive signed 7, then -1, then 0 on back-to-back cycles → out_float = 0x40E00000, 0xBF800000, 0x00000000 on cycles 3, 4, 5 after the first accept; out_inexact=0 for all three.
- Extremes:
  - signed 0x80000000 → 0xCF000000, inexact=0.
  - unsigned 0xFFFFFFFF → 0x4F800000, inexact=1.
  - signed 0x7FFFFFFF → 0x4F000000, inexact=1.
- Round-nearest-even (unsigned):
  - 16777217 → 0x4B800000, inexact=1 (tie to even, down).
  - 16777219 → 0x4B800002, inexact=1 (tie, round up).
  - 16777216 → 0x4B800000, inexact=0.
- Backpressure: stream 5 operands with out_ready low for 4 cycles mid-stream → in_ready=0 once S1–S3 are all valid; out_float holds stable; all 5 results emerge in order with no loss or duplication.
- Mid-operation reset: accept 2 operands, then assert reset_n low for 1 cycle before any output → out_valid=0 immediately; no stale result appears after release; the next operand (unsigned 1) → 0x3F800000 exactly 3 cycles after its accept.
- Narrow width: INT_WIDTH=8 → signed 0x80 → 0xC3000000; unsigned 0x80 → 0x43000000; signed 0xFF → 0xBF800000.
